// File: rtl/cache_line_arbiter.sv
// cache_line_arbiter: round-robin arbiter between I- and D-cache for a single line adapter.
// A grant can carry a writeback followed by a fill before its completion pulse.
module cache_line_arbiter #(
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 24,
    parameter int LINE_W = 256
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [1:0]        rd_req,
    input  logic [1:0]        wr_req,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [TAG_W-1:0]  req_tag0,
    input  logic [TAG_W-1:0]  req_tag1,
    input  logic [LINE_W-1:0] req_wdata0,
    input  logic [LINE_W-1:0] req_wdata1,
    output logic [1:0]        req_done,
    output logic [LINE_W-1:0] req_rdata,
    output logic              cl_read,
    output logic              cl_write,
    output logic [ADDR_W-1:0] cl_addr,
    output logic [TAG_W-1:0]  cl_tag,
    output logic [LINE_W-1:0] cl_wdata,
    input  logic [LINE_W-1:0] cl_rdata,
    input  logic              cl_busy
);
    typedef enum logic [2:0] {IDLE, ISSUE_WR, WAIT_WR, ISSUE_RD, WAIT_RD, DONE} state_t;
    state_t state, state_nx;
    logic       last_grant, lat_rd, seen_busy, gnt_nx, wait_done, in_wait, to_issue;
    logic [1:0] pend;
    always_comb begin
        pend      = rd_req | wr_req;
        gnt_nx    = &pend ? ~last_grant : pend[1];
        wait_done = seen_busy && !cl_busy;
        in_wait   = state == WAIT_WR || state == WAIT_RD;
        state_nx  = state;
        case (state)
            IDLE:     state_nx = |pend ? (wr_req[gnt_nx] ? ISSUE_WR : ISSUE_RD) : IDLE;
            ISSUE_WR: state_nx = WAIT_WR;
            WAIT_WR:  state_nx = wait_done ? (lat_rd ? ISSUE_RD : DONE) : WAIT_WR;
            ISSUE_RD: state_nx = WAIT_RD;
            WAIT_RD:  state_nx = wait_done ? DONE : WAIT_RD;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
        to_issue = state_nx == ISSUE_WR || state_nx == ISSUE_RD;
        cl_read  = state == ISSUE_RD;
        cl_write = state == ISSUE_WR;
        req_done = state == DONE ? (last_grant ? 2'b10 : 2'b01) : 2'b00;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            last_grant <= 1'b0;
            lat_rd     <= 1'b0;
            seen_busy  <= 1'b0;
            cl_addr    <= '0;
            cl_tag     <= '0;
            cl_wdata   <= '0;
            req_rdata  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && |pend) begin
                last_grant <= gnt_nx;
                lat_rd     <= rd_req[gnt_nx];
                cl_addr    <= gnt_nx ? req_addr1 : req_addr0;
                cl_tag     <= gnt_nx ? req_tag1 : req_tag0;
                cl_wdata   <= gnt_nx ? req_wdata1 : req_wdata0;
            end
            // busy must be observed high in WAIT before its fall can end the transfer
            seen_busy <= to_issue ? 1'b0 : seen_busy | (in_wait & cl_busy);
            if (state == WAIT_RD && wait_done)
                req_rdata <= cl_rdata;
        end
    end
endmodule

// File: tb/tb_cache_line_arbiter.sv
// tb_cache_line_arbiter: random requesters and adapter against a transaction-level model.
module tb_cache_line_arbiter;
    localparam int AW = 32, TW = 24, LW = 256;
    logic          CLK = 1'b0, RST = 1'b1;
    logic [1:0]    rd_req = '0, wr_req = '0, req_done;
    logic [AW-1:0] req_addr0 = '0, req_addr1 = '0, cl_addr;
    logic [TW-1:0] req_tag0 = '0, req_tag1 = '0, cl_tag;
    logic [LW-1:0] req_wdata0 = '0, req_wdata1 = '0, req_rdata, cl_wdata, cl_rdata = '0;
    logic          cl_read, cl_write, cl_busy = 1'b0;
    always #5 CLK = ~CLK;

    cache_line_arbiter dut (
        .CLK(CLK), .RST(RST), .rd_req(rd_req), .wr_req(wr_req),
        .req_addr0(req_addr0), .req_addr1(req_addr1), .req_tag0(req_tag0), .req_tag1(req_tag1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1), .req_done(req_done), .req_rdata(req_rdata),
        .cl_read(cl_read), .cl_write(cl_write), .cl_addr(cl_addr), .cl_tag(cl_tag),
        .cl_wdata(cl_wdata), .cl_rdata(cl_rdata), .cl_busy(cl_busy)
    );

    int vecs = 0, errs = 0;
    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] l;
        for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // requester state per port
    bit            r_act [2], r_rd [2], r_wr [2], r_cool [2];
    logic [AW-1:0] r_addr [2];
    logic [TW-1:0] r_tag [2];
    logic [LW-1:0] r_data [2];
    // model: one transaction in flight, events scheduled by cycle number
    bit            m_busy, m_own, m_last, m_rd, m_inrd;
    int            m_ev, m_ev_cyc, ev;
    logic [AW-1:0] m_addr;
    logic [TW-1:0] m_tag;
    logic [LW-1:0] m_data, m_rdata, ad_line;
    // adapter: busy window [ad_start, ad_end]
    int            ad_start = -1, ad_end = -1, d, len, resets = 0;
    bit            ad_isrd, rst_req, rst_chk;
    logic [1:0]    exp_done;
    logic [2:0]    kind;

    initial begin
        m_busy = 0; m_last = 0; m_ev = 0; m_ev_cyc = -1; m_rdata = '0; rst_req = 0; rst_chk = 0;
        for (int p = 0; p < 2; p++) begin r_act[p] = 0; r_cool[p] = 0; end
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset_cmd", LW'({cl_read, cl_write, req_done}), '0);
        chk("reset_addr", LW'(cl_addr), '0);
        chk("reset_tag", LW'(cl_tag), '0);
        chk("reset_wdata", cl_wdata, '0);
        chk("reset_rdata", req_rdata, '0);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge CLK); #1;
            RST = rst_req;
            for (int p = 0; p < 2; p++) begin
                if (r_cool[p]) r_cool[p] = 0;
                else if (!r_act[p] && (cyc == 0 || $urandom_range(0, 3) == 0)) begin
                    kind = (cyc == 0) ? 3'd1 : 3'($urandom_range(1, 3));
                    r_act[p] = 1; r_rd[p] = kind[0]; r_wr[p] = kind[1];
                    r_addr[p] = $urandom; r_tag[p] = TW'($urandom); r_data[p] = rnd_line();
                end else if (m_busy && m_own == 1'(p) && $urandom_range(0, 2) == 0) begin
                    r_addr[p] = $urandom; r_tag[p] = TW'($urandom); r_data[p] = rnd_line();
                end
            end
            rd_req = {r_act[1] & r_rd[1], r_act[0] & r_rd[0]};
            wr_req = {r_act[1] & r_wr[1], r_act[0] & r_wr[0]};
            req_addr0 = r_addr[0]; req_addr1 = r_addr[1];
            req_tag0 = r_tag[0]; req_tag1 = r_tag[1];
            req_wdata0 = r_data[0]; req_wdata1 = r_data[1];
            cl_busy = cyc >= ad_start && cyc <= ad_end;
            cl_rdata = (ad_isrd && cyc >= ad_end) ? ad_line : rnd_line();
            @(negedge CLK);
            ev = (m_ev_cyc == cyc) ? m_ev : 0;
            exp_done = (ev == 3) ? (m_own ? 2'b10 : 2'b01) : 2'b00;
            chk("cmd", LW'({cl_read, cl_write, req_done}), LW'({ev == 2, ev == 1, exp_done}));
            chk("done_onehot0", LW'($onehot0(req_done)), LW'(1'b1));
            if (rst_chk) begin
                chk("post_rst_addr", LW'(cl_addr), '0);
                chk("post_rst_tag", LW'(cl_tag), '0);
                chk("post_rst_wdata", cl_wdata, '0);
                rst_chk = 0;
            end else if (m_busy) begin
                chk("cl_addr", LW'(cl_addr), LW'(m_addr));
                chk("cl_tag", LW'(cl_tag), LW'(m_tag));
                chk("cl_wdata", cl_wdata, m_data);
            end
            if (ev == 3 && m_rd) m_rdata = ad_line;
            chk("rdata", req_rdata, m_rdata);
            if (rst_req) begin
                m_busy = 0; m_ev = 0; m_last = 0; m_rdata = '0; m_inrd = 0;
                ad_start = -1; ad_end = -1; ad_isrd = 0;
                for (int p = 0; p < 2; p++) begin r_act[p] = 0; r_cool[p] = 0; end
                rst_req = 0; rst_chk = 1; resets++;
            end else if (ev == 1 || ev == 2) begin
                d = $urandom_range(0, 3); len = $urandom_range(1, 9);
                ad_start = cyc + 1 + d; ad_end = cyc + d + len; ad_isrd = (ev == 2);
                if (ev == 2) ad_line = rnd_line();
                m_ev_cyc = cyc + d + len + 2;
                m_ev = (ev == 1 && m_rd) ? 2 : 3;
                m_inrd = (ev == 2);
            end else if (ev == 3) begin
                m_busy = 0; m_ev = 0; r_act[m_own] = 0; r_cool[m_own] = 1;
            end else if (!m_busy && (r_act[0] || r_act[1])) begin
                m_own = (r_act[0] && r_act[1]) ? ~m_last : r_act[1];
                m_last = m_own; m_busy = 1; m_inrd = 0;
                m_rd = r_rd[m_own];
                m_addr = r_addr[m_own]; m_tag = r_tag[m_own]; m_data = r_data[m_own];
                m_ev_cyc = cyc + 1; m_ev = r_wr[m_own] ? 1 : 2;
            end
            // occasionally reset while a fill is waiting with the adapter busy
            if (!rst_chk && m_busy && m_inrd && cl_busy && ad_end > cyc && cyc > 50 &&
                $urandom_range(0, 5) == 0)
                rst_req = 1;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
